imm_decode_stage: RTL and testbench



---
 rtl/imm_decode_stage.sv | 142 ++++++++++++++
 tb/tb_imm_decode_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Two-stage RV32I immediate decode: S1 classifies the opcode, S2 sign-extends.
// Valid/ready on both sides with flush; a saturating counter tallies delivered illegal opcodes.

module imm_signext (
  input  logic [31:7] instr,
  input  logic [2:0]  sel,
  output logic [31:0] imm
);
  always_comb begin
    imm = '0;
    case (sel)
      3'd0:    imm = {{20{instr[31]}}, instr[31:20]};
      3'd1:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'd2:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd3:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'd4:    imm = {instr[31:12], 12'b0};
      default: imm = '0;
    endcase
  end
endmodule

module imm_decode_stage #(
  parameter int TAGW = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_sel,
  output logic            out_has_imm,
  output logic            out_illegal,
  output logic [TAGW-1:0] out_tag,
  output logic [CNTW-1:0] illegal_cnt
);

  // Returns {sel[2:0], has_imm, illegal}; any opcode not ending in 2'b11 falls to default.
  function automatic logic [4:0] decode(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b1110011, 7'b0001111: decode = {3'd0, 1'b1, 1'b0};
      7'b0100011:             decode = {3'd1, 1'b1, 1'b0};
      7'b1100011:             decode = {3'd2, 1'b1, 1'b0};
      7'b1101111:             decode = {3'd3, 1'b1, 1'b0};
      7'b0110111, 7'b0010111: decode = {3'd4, 1'b1, 1'b0};
      7'b0110011:             decode = {3'd0, 1'b0, 1'b0};
      default:                decode = {3'd0, 1'b0, 1'b1};
    endcase
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  logic            vld_p1, vld_p2;
  logic [31:7]     instr_p1;
  logic [TAGW-1:0] tag_p1, tag_p2;
  logic [2:0]      sel_p1, sel_p2;
  logic            has_imm_p1, has_imm_p2;
  logic            illegal_p1, illegal_p2;
  logic [31:0]     imm_p2;
  logic [CNTW-1:0] cnt;

  logic        s2_adv, s1_adv, s1_load, in_fire, out_fire;
  logic [4:0]  dec;
  logic [31:0] ext;

  assign s2_adv   = !vld_p2 | out_ready;
  assign s1_adv   = vld_p1 & s2_adv;
  assign s1_load  = !vld_p1 | s2_adv;
  assign in_ready = reset_n & s1_load & !flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p2 & out_ready & !flush;
  assign dec      = decode(in_instr[6:0]);

  imm_signext u_signext (
    .instr (instr_p1),
    .sel   (sel_p1),
    .imm   (ext)
  );

  // Stage 1: capture instruction, tag and opcode class
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      tag_p1     <= '0;
      sel_p1     <= '0;
      has_imm_p1 <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      if (flush)        vld_p1 <= 1'b0;
      else if (s1_load) vld_p1 <= in_valid;
      if (in_fire) begin
        instr_p1   <= in_instr[31:7];
        tag_p1     <= in_tag;
        sel_p1     <= dec[4:2];
        has_imm_p1 <= dec[1];
        illegal_p1 <= dec[0];
      end
    end
  end

  // Stage 2: extended immediate, zeroed for formats without one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2     <= 1'b0;
      imm_p2     <= '0;
      tag_p2     <= '0;
      sel_p2     <= '0;
      has_imm_p2 <= 1'b0;
      illegal_p2 <= 1'b0;
      cnt        <= '0;
    end else begin
      if (flush)       vld_p2 <= 1'b0;
      else if (s2_adv) vld_p2 <= vld_p1;
      if (s1_adv) begin
        imm_p2     <= has_imm_p1 ? ext : 32'd0;
        tag_p2     <= tag_p1;
        sel_p2     <= sel_p1;
        has_imm_p2 <= has_imm_p1;
        illegal_p2 <= illegal_p1;
      end
      if (out_fire && illegal_p2) cnt <= sat_inc(cnt);
    end
  end

  assign out_valid   = vld_p2;
  assign out_imm     = imm_p2;
  assign out_sel     = sel_p2;
  assign out_has_imm = has_imm_p2;
  assign out_illegal = illegal_p2;
  assign out_tag     = tag_p2;
  assign illegal_cnt = cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: vector table streamed through a scoreboard queue,
// plus latency, backpressure, flush, async reset and counter saturation sequences.

module tb_imm_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic        has_imm;
    logic        illegal;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_sel;
  logic        out_has_imm;
  logic        out_illegal;
  logic [31:0] out_tag;
  logic [15:0] illegal_cnt;

  imm_decode_stage #(.TAGW(32), .CNTW(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_sel     (out_sel),
    .out_has_imm (out_has_imm),
    .out_illegal (out_illegal),
    .out_tag     (out_tag),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nfail = 0;
  vec_t        q[$];
  vec_t        cur;
  vec_t        tbl[16];
  vec_t        e;
  logic        accepted;
  logic [15:0] exp_cnt = '0;
  logic [15:0] cnt_before;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] tag,
                              input logic [31:0] imm, input logic [2:0] sel,
                              input logic h, input logic il);
    vec_t v;
    v.instr = instr; v.tag = tag; v.imm = imm; v.sel = sel; v.has_imm = h; v.illegal = il;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called #1 after a falling edge: scores the handshakes that the next rising edge completes.
  task automatic sample();
    accepted = 1'b0;
    chk("illegal_cnt", {48'd0, illegal_cnt}, {48'd0, exp_cnt});
    if (out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL unexpected_out: got tag 0x%0h, expected no output", out_tag);
      end else begin
        e = q.pop_front();
        chk("out_imm",     {32'd0, out_imm}, {32'd0, e.imm});
        chk("out_sel",     {61'd0, out_sel}, {61'd0, e.sel});
        chk("out_has_imm", {63'd0, out_has_imm}, {63'd0, e.has_imm});
        chk("out_illegal", {63'd0, out_illegal}, {63'd0, e.illegal});
        chk("out_tag",     {32'd0, out_tag}, {32'd0, e.tag});
        if (e.illegal && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) begin
      q.push_back(cur);
      accepted = 1'b1;
    end
  endtask

  task automatic step();
    #1 sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input vec_t v);
    cur = v; in_instr = v.instr; in_tag = v.tag; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) begin
      nvec++; nfail++;
      $display("FAIL send_timeout: got no accept, expected accept of tag 0x%0h", v.tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      step();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic latency(input vec_t v);
    out_ready = 1'b1;
    cur = v; in_instr = v.instr; in_tag = v.tag; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    step();
    chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    step();
    chk("lat_popped", 64'(q.size()), 64'd0);
  endtask

  initial begin
    tbl[0]  = mk(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0); // addi -1
    tbl[1]  = mk(32'hFE112E23, 32'h104, 32'hFFFFFFFC, 3'd1, 1'b1, 1'b0); // sw -4
    tbl[2]  = mk(32'h123452B7, 32'h108, 32'h12345000, 3'd4, 1'b1, 1'b0); // lui
    tbl[3]  = mk(32'hFF9FF06F, 32'h10C, 32'hFFFFFFF8, 3'd3, 1'b1, 1'b0); // jal -8
    tbl[4]  = mk(32'hFE000EE3, 32'h110, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b0); // beq -4
    tbl[5]  = mk(32'h00001017, 32'h114, 32'h00001000, 3'd4, 1'b1, 1'b0); // auipc
    tbl[6]  = mk(32'h00412083, 32'h118, 32'h00000004, 3'd0, 1'b1, 1'b0); // lw 4
    tbl[7]  = mk(32'h000080E7, 32'h11C, 32'h00000000, 3'd0, 1'b1, 1'b0); // jalr 0
    tbl[8]  = mk(32'h30529073, 32'h120, 32'h00000305, 3'd0, 1'b1, 1'b0); // csrrw
    tbl[9]  = mk(32'h0FF0000F, 32'h124, 32'h000000FF, 3'd0, 1'b1, 1'b0); // fence
    tbl[10] = mk(32'h0000007F, 32'h128, 32'h00000000, 3'd0, 1'b0, 1'b1); // illegal
    tbl[11] = mk(32'h002081B3, 32'h12C, 32'h00000000, 3'd0, 1'b0, 1'b0); // add
    tbl[12] = mk(32'hFFF00010, 32'h130, 32'h00000000, 3'd0, 1'b0, 1'b1); // low bits 00
    tbl[13] = mk(32'h0010006F, 32'h134, 32'h00000800, 3'd3, 1'b1, 1'b0); // jal +2048
    tbl[14] = mk(32'h000000E3, 32'h138, 32'h00000800, 3'd2, 1'b1, 1'b0); // beq +2048
    tbl[15] = mk(32'h7E000FA3, 32'h13C, 32'h000007FF, 3'd1, 1'b1, 1'b0); // sw +2047

    // Reset state
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_imm",   {32'd0, out_imm}, 64'd0);
    chk("rst_out_tag",   {32'd0, out_tag}, 64'd0);
    chk("rst_cnt",       {48'd0, illegal_cnt}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    latency(tbl[0]);

    // Full-rate stream of the whole table
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(tbl[i]);
    drain();
    chk("cnt_after_table", {48'd0, illegal_cnt}, 64'd2);

    // Backpressure: two accepts fill the pipe, the third waits
    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[2]);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    cur = tbl[3]; in_instr = tbl[3].instr; in_tag = tbl[3].tag; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_tag",   {32'd0, out_tag}, {32'd0, q[0].tag});
      chk("bp_hold_imm",   {32'd0, out_imm}, {32'd0, q[0].imm});
    end
    out_ready = 1'b1;
    send(tbl[3]);
    drain();

    // Flush with both stages full, input pending and consumer ready
    out_ready = 1'b0;
    send(tbl[10]);
    send(tbl[12]);
    cnt_before = exp_cnt;
    cur = tbl[11]; in_instr = tbl[11].instr; in_tag = tbl[11].tag; in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    #1 chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    #0 step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready_after", {63'd0, in_ready}, 64'd1);
    chk("flush_cnt", {48'd0, illegal_cnt}, {48'd0, cnt_before});
    @(negedge clk);
    step();
    chk("flush_no_ghost", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b1;
    cur = tbl[5]; in_instr = tbl[5].instr; in_tag = tbl[5].tag; in_valid = 1'b1;
    step();
    step();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_out_valid",   {63'd0, out_valid}, 64'd0);
    chk("arst_out_imm",     {32'd0, out_imm}, 64'd0);
    chk("arst_out_sel",     {61'd0, out_sel}, 64'd0);
    chk("arst_out_has_imm", {63'd0, out_has_imm}, 64'd0);
    chk("arst_out_illegal", {63'd0, out_illegal}, 64'd0);
    chk("arst_out_tag",     {32'd0, out_tag}, 64'd0);
    chk("arst_cnt",         {48'd0, illegal_cnt}, 64'd0);
    in_valid = 1'b0;
    q.delete();
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    latency(tbl[4]);

    // Long illegal run drives the counter into saturation
    out_ready = 1'b1;
    for (int i = 0; i < 65545; i++) send(tbl[10]);
    drain();
    chk("cnt_saturated", {48'd0, illegal_cnt}, 64'h000000000000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
